// File: rtl/e203_expl_axi_sram_pkg.sv
// Shared encodings for the exported-AXI scratch SRAM slave:
// burst types, response codes and controller states.
package e203_expl_axi_sram_pkg;

    localparam int E203_ADDR_SIZE = 32;
    localparam int E203_XLEN      = 32;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_WR_DATA,
        ST_WR_RESP
    } state_e;

    function automatic logic is_wrap_len(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) ||
               (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/e203_expl_axi_addr_gen.sv
// Beat address generator: next address for FIXED/INCR/WRAP bursts,
// SRAM word index of the current beat and its window range check.
module e203_expl_axi_addr_gen
    import e203_expl_axi_sram_pkg::*;
#(
    parameter int          DEPTH = 4096,
    parameter logic [31:0] BASE  = 32'h0,
    localparam int         SAW   = $clog2(DEPTH)
) (
    input  logic [31:0]    addr_i,
    input  logic [1:0]     burst_i,
    input  logic [3:0]     len_i,
    output logic [31:0]    next_addr_o,
    output logic [SAW-1:0] word_addr_o,
    output logic           oor_o
);

    localparam logic [31:0] WIN = 32'(DEPTH) << 2;

    logic [31:0] off;
    logic [31:0] incr_off;
    logic [31:0] wrap_bytes;
    logic [31:0] wrap_mask;
    logic        is_fixed;
    logic        is_wrap;

    always_comb begin
        off         = addr_i - BASE;
        oor_o       = off >= WIN;
        word_addr_o = off[SAW+1:2];
        // INCR wraps within the window rather than leaving it
        incr_off    = (off + 32'd4) & (WIN - 32'd1);
        wrap_bytes  = {25'd0, {1'b0, len_i} + 5'd1, 2'b00};
        wrap_mask   = wrap_bytes - 32'd1;
        is_fixed    = burst_i == BURST_FIXED;
        is_wrap     = (burst_i == BURST_WRAP) && is_wrap_len(len_i);
        next_addr_o = BASE + incr_off;
        unique case (1'b1)
            is_fixed: next_addr_o = addr_i;
            is_wrap:  next_addr_o = (addr_i & ~wrap_mask) |
                                    ((addr_i + 32'd4) & wrap_mask);
            default:  next_addr_o = BASE + incr_off;
        endcase
    end

endmodule

// File: rtl/e203_expl_axi_sram.sv
// AXI3-style slave terminating expl_axi_* onto one single-port SRAM;
// serialises read and write bursts, one transaction in flight.
module e203_expl_axi_sram
    import e203_expl_axi_sram_pkg::*;
#(
    parameter int          DEPTH = 4096,
    parameter logic [31:0] BASE  = 32'h0,
    localparam int         SAW   = $clog2(DEPTH),
    localparam int         AW    = E203_ADDR_SIZE,
    localparam int         XL    = E203_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            expl_axi_arvalid_i,
    output logic            expl_axi_arready_o,
    input  logic [AW-1:0]   expl_axi_araddr_i,
    input  logic [3:0]      expl_axi_arcache_i,
    input  logic [2:0]      expl_axi_arprot_i,
    input  logic [1:0]      expl_axi_arlock_i,
    input  logic [1:0]      expl_axi_arburst_i,
    input  logic [3:0]      expl_axi_arlen_i,
    input  logic [2:0]      expl_axi_arsize_i,
    input  logic            expl_axi_awvalid_i,
    output logic            expl_axi_awready_o,
    input  logic [AW-1:0]   expl_axi_awaddr_i,
    input  logic [3:0]      expl_axi_awcache_i,
    input  logic [2:0]      expl_axi_awprot_i,
    input  logic [1:0]      expl_axi_awlock_i,
    input  logic [1:0]      expl_axi_awburst_i,
    input  logic [3:0]      expl_axi_awlen_i,
    input  logic [2:0]      expl_axi_awsize_i,
    output logic            expl_axi_rvalid_o,
    input  logic            expl_axi_rready_i,
    output logic [XL-1:0]   expl_axi_rdata_o,
    output logic [1:0]      expl_axi_rresp_o,
    output logic            expl_axi_rlast_o,
    input  logic            expl_axi_wvalid_i,
    output logic            expl_axi_wready_o,
    input  logic [XL-1:0]   expl_axi_wdata_i,
    input  logic [XL/8-1:0] expl_axi_wstrb_i,
    input  logic            expl_axi_wlast_i,
    output logic            expl_axi_bvalid_o,
    input  logic            expl_axi_bready_i,
    output logic [1:0]      expl_axi_bresp_o,
    output logic            sram_cs_o,
    output logic            sram_we_o,
    output logic [SAW-1:0]  sram_addr_o,
    output logic [31:0]     sram_wdata_o,
    output logic [3:0]      sram_wem_o,
    input  logic [31:0]     sram_rdata_i
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [1:0]  burst_q, burst_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        prio_q, prio_d;

    logic [31:0] next_addr;
    logic        oor;
    logic        last;
    logic        unused_ok;

    assign unused_ok = ^{expl_axi_arcache_i, expl_axi_arprot_i,
                         expl_axi_arlock_i, expl_axi_arsize_i,
                         expl_axi_awcache_i, expl_axi_awprot_i,
                         expl_axi_awlock_i, expl_axi_awsize_i};

    e203_expl_axi_addr_gen #(
        .DEPTH (DEPTH),
        .BASE  (BASE)
    ) u_addr_gen (
        .addr_i      (addr_q),
        .burst_i     (burst_q),
        .len_i       (len_q),
        .next_addr_o (next_addr),
        .word_addr_o (sram_addr_o),
        .oor_o       (oor)
    );

    assign last = cnt_q == len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            prio_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        len_d              = len_q;
        burst_d            = burst_q;
        cnt_d              = cnt_q;
        err_d              = err_q;
        prio_d             = prio_q;
        expl_axi_arready_o = 1'b0;
        expl_axi_awready_o = 1'b0;
        expl_axi_rvalid_o  = 1'b0;
        expl_axi_rdata_o   = '0;
        expl_axi_rresp_o   = RESP_OKAY;
        expl_axi_rlast_o   = 1'b0;
        expl_axi_wready_o  = 1'b0;
        expl_axi_bvalid_o  = 1'b0;
        expl_axi_bresp_o   = RESP_OKAY;
        sram_cs_o          = 1'b0;
        sram_we_o          = 1'b0;
        sram_wdata_o       = '0;
        sram_wem_o         = '0;
        unique case (state_q)
            ST_IDLE: begin
                expl_axi_arready_o = !expl_axi_awvalid_i | prio_q;
                expl_axi_awready_o = !expl_axi_arvalid_i | !prio_q;
                if (expl_axi_arvalid_i && expl_axi_arready_o) begin
                    addr_d  = expl_axi_araddr_i;
                    len_d   = expl_axi_arlen_i;
                    burst_d = expl_axi_arburst_i;
                    cnt_d   = '0;
                    err_d   = expl_axi_arburst_i == BURST_RSVD;
                    prio_d  = 1'b0;
                    state_d = ST_RD_REQ;
                end else if (expl_axi_awvalid_i && expl_axi_awready_o) begin
                    addr_d  = expl_axi_awaddr_i;
                    len_d   = expl_axi_awlen_i;
                    burst_d = expl_axi_awburst_i;
                    cnt_d   = '0;
                    err_d   = expl_axi_awburst_i == BURST_RSVD;
                    prio_d  = 1'b1;
                    state_d = ST_WR_DATA;
                end
            end
            ST_RD_REQ: begin
                // range error is sticky for the rest of the burst
                sram_cs_o = !oor;
                err_d     = err_q | oor;
                state_d   = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                expl_axi_rvalid_o = 1'b1;
                expl_axi_rdata_o  = err_q ? '0 : sram_rdata_i;
                expl_axi_rresp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
                expl_axi_rlast_o  = last;
                if (expl_axi_rready_i) begin
                    if (last) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        addr_d  = next_addr;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_WR_DATA: begin
                expl_axi_wready_o = 1'b1;
                if (expl_axi_wvalid_i) begin
                    sram_cs_o    = !oor;
                    sram_we_o    = !oor;
                    sram_wdata_o = expl_axi_wdata_i;
                    sram_wem_o   = expl_axi_wstrb_i;
                    err_d = err_q | oor | (expl_axi_wlast_i != last);
                    if (last) begin
                        state_d = ST_WR_RESP;
                    end else begin
                        cnt_d  = cnt_q + 4'd1;
                        addr_d = next_addr;
                    end
                end
            end
            ST_WR_RESP: begin
                expl_axi_bvalid_o = 1'b1;
                expl_axi_bresp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (expl_axi_bready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/e203_expl_axi_sram.md
# e203_expl_axi_sram

AXI3-style slave that terminates the SoC's exported `expl_axi_*` master port and maps it onto one single-port synchronous SRAM of `DEPTH` 32-bit words. It sits directly downstream of the SoC top, as an off-subsystem scratch memory. It serialises read and write bursts onto the one SRAM port, generates FIXED/INCR/WRAP beat addresses, and returns OKAY or SLVERR responses.

## Interface
- `DEPTH`, 4096: SRAM words; power of two. `SAW = clog2(DEPTH)`.
- `BASE`, 32'h0: byte base address of the window.
- `clk  in  1`: sole clock.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `expl_axi_ar{valid,ready,addr,cache,prot,lock,burst,len,size}`: slave side, widths as exported (addr `E203_ADDR_SIZE`, lock/burst 2, len 4, size 3). cache/prot/lock/size are ignored; size is always treated as 4 bytes.
- `expl_axi_aw{...}`: same fields as AR.
- `expl_axi_r{valid,ready,data,resp,last}`: data `E203_XLEN`, resp 2.
- `expl_axi_w{valid,ready,data,strb,last}`: strb `E203_XLEN/8`.
- `expl_axi_b{valid,ready,resp}`: resp 2.
- `sram_cs  out  1`: access enable.
- `sram_we  out  1`: 1 = write.
- `sram_addr  out  SAW`: word address.
- `sram_wdata  out  32`, `sram_wem  out  4`: write data and byte enables.
- `sram_rdata  in  32`: valid the cycle after a read `cs`; held by the SRAM until its next `cs`.

## Operation
- FSM states: IDLE, RD_REQ, RD_RESP, WR_DATA, WR_RESP.
- IDLE handshakes:
  - `arready = IDLE & (!awvalid | prio_rd)`; `awready = IDLE & (!arvalid | !prio_rd)`.
  - At most one address is accepted per cycle.
  - `prio_rd` resets to 1. It toggles to favour the other channel after every granted burst.
- Accepted address, len, and burst are latched. The beat counter `cnt` clears to 0. `err` is set if the burst is out of range or the burst type is reserved.
  - Out of range: `addr - BASE >= DEPTH*4`, evaluated per beat.
  - Reserved burst: 2'b11.
- Address generation per beat:
  - FIXED: address constant.
  - INCR: +4, wrapping modulo the window.
  - WRAP: boundary is `(len+1)*4`. This applies only when len ∈ {1,3,7,15}; any other len is treated as INCR.
- Read flow: AR grant → RD_REQ.
  - RD_REQ: `sram_cs=1, we=0`. If the beat is out of range, `cs` stays 0. Then go to RD_RESP.
  - RD_RESP: `rvalid=1`. `rdata = sram_rdata`, or 0 on error. `rresp` = 2'b10 on error, else 2'b00. `rlast = (cnt==len)`.
  - On `rvalid&rready`: if last, go to IDLE; else `cnt++`, advance the address, go to RD_REQ.
  - Throughput is one beat per 2 cycles minimum.
- Write flow: AW grant → WR_DATA.
  - WR_DATA: `wready=1`.
  - Each `wvalid&wready` drives `sram_cs=1, we=1, wem=wstrb, wdata=wdata` in the same cycle. Out-of-range beats are suppressed.
  - Burst termination is by `cnt==len`, not by `wlast`. If `wlast` does not match `cnt==len`, set `err`.
  - After the final beat, go to WR_RESP.
- WR_RESP: `bvalid=1`, `bresp` = `err`?2'b10:2'b00. On `bready`, go to IDLE.
- While a burst is active, the opposite channel's ready stays 0. No outstanding transactions beyond one.

## Timing
- Reset values: state IDLE, all valids 0, `wready`/`sram_cs`/`sram_we` 0, `rdata`/`rresp`/`bresp` 0, `cnt` 0, `err` 0, `prio_rd` 1.
- Readies in IDLE are combinational from the opposite valid; the AXI spec permits this.
- Read latency: AR handshake at cycle N → `rvalid` at N+2.
- Write latency: AW handshake at N → `wready` at N+1. Last W beat at M → `bvalid` at M+1.
- `rvalid`/`bvalid` hold, and `rdata`/`rresp`/`rlast` stay stable, until the handshake completes.
- Simultaneous AR and AW in IDLE: the one favoured by `prio_rd` wins. The loser's valid stays pending and is granted next IDLE.
- Deasserting `rst_n` mid-burst aborts immediately to reset values. No partial B/R is emitted.

## Structure
- Shared constants go in the codebase's common defines/package:
  - burst encodings FIXED/INCR/WRAP;
  - resp codes OKAY/SLVERR;
  - FSM state encodings.
- One sub-module, `e203_expl_axi_addr_gen`: combinational next address from (addr, burst, len) plus the range-check flag.

## Test plan
- Single-beat write then read:
  - AW addr 0x10, W data 0xDEADBEEF, strb 4'hF → `bresp` 00.
  - AR 0x10 → `rdata` 0xDEADBEEF, `rlast` 1, `rvalid` at AR+2.
- INCR len=3 write of 1,2,3,4 at 0x100, then INCR read → rdata 1,2,3,4; `rlast` only on the 4th beat.
- WRAP len=3 read at 0x108 → beat addresses 0x108, 0x10C, 0x100, 0x104.
- Strb 4'b0101 write of 0xAABBCCDD over 0 → read returns 0x00BB00DD.
- Out-of-range AR (`BASE + DEPTH*4`) → `rresp` 10, `rdata` 0, no `sram_cs`.
- Error and arbitration cases:
  - W with `wlast` early on len=1 → `bresp` 10.
  - AR and AW asserted together from reset → read granted first, write next.
  - `rst_n` pulsed mid-burst → all valids 0.
